fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares the single push port of one sample FIFO between `NUM_REQ` producers in the timeseries-predictor datapath. Each producer presents one sample at a time with a request. The arbiter grants one producer per cycle and drives the FIFO's `val_in`/`push` from registers. It also keeps its own occupancy count, so a push is never issued into a full FIFO.

---
 rtl/fifo_push_arbiter.sv | 92 +++++++++
 tb/tb_fifo_push_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter sharing one FIFO push port between producers
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          hold,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         fifo_val_in,
    output logic                          fifo_push,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_pop,
    output logic [DEPTH_BITS:0]           level,
    output logic                          overflow_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [DEPTH_BITS:0] DEPTH = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] LVL_ONE = (DEPTH_BITS+1)'(1);

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [PTR_W-1:0]      winner;
    logic [PTR_W:0]        idx_w;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant_next;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  issue;
    logic                  pop_dec;
    logic [DEPTH_BITS:0]   level_next;

    // Masking the currently granted producer stops its old sample from being pushed twice.
    always_comb begin
        eligible   = (hold || level == DEPTH) ? '0 : (req & ~grant);
        issue      = 1'b0;
        winner     = '0;
        grant_next = '0;
        idx_w      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
            if (!issue && eligible[idx_w[PTR_W-1:0]]) begin
                issue                          = 1'b1;
                winner                         = idx_w[PTR_W-1:0];
                grant_next[idx_w[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_next[i]) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        ptr_next = ({1'b0, winner} == NREQ_W - (PTR_W+1)'(1)) ? '0 : winner + PTR_W'(1);
    end

    // A pop is only honoured when the FIFO actually holds an entry.
    always_comb begin
        pop_dec    = fifo_pop && !fifo_empty && (level != '0);
        level_next = level;
        if (issue && !pop_dec)      level_next = level + LVL_ONE;
        else if (!issue && pop_dec) level_next = level - LVL_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant        <= '0;
            fifo_push    <= 1'b0;
            fifo_val_in  <= '0;
            level        <= '0;
            overflow_err <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            grant     <= grant_next;
            fifo_push <= issue;
            if (issue) begin
                fifo_val_in <= win_data;
                rr_ptr      <= ptr_next;
            end
            level        <= level_next;
            overflow_err <= overflow_err | (fifo_push & fifo_full);
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DB = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*DW-1:0] req_data;
    logic          hold;
    logic [NR-1:0] grant;
    logic [DW-1:0] fifo_val_in;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DB:0]   level;
    logic          overflow_err;

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH_BITS(DB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .hold(hold),
        .grant(grant), .fifo_val_in(fifo_val_in), .fifo_push(fifo_push),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .level(level), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample FIFO seen by the arbiter: only its occupancy matters here.
    int f_cnt;
    assign fifo_full  = (f_cnt == DEPTH);
    assign fifo_empty = (f_cnt == 0);
    always @(posedge clk or negedge rst) begin
        if (!rst) f_cnt <= 0;
        else f_cnt <= f_cnt + ((fifo_push && f_cnt < DEPTH) ? 1 : 0) - ((fifo_pop && f_cnt > 0) ? 1 : 0);
    end

    // Reference: who wins this cycle, by scanning producers in rotation from the pointer.
    function automatic int pick(input logic [NR-1:0] r, input int ptr, input int last,
                                input logic h, input int lvl);
        if (h || lvl >= DEPTH) return -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
            if (r[i] && i != last) return i;
        end
        return -1;
    endfunction

    int          m_ptr, m_level, m_win, m_nw;
    logic [DW-1:0] m_data;
    logic        m_push, m_ovf;

    always_comb m_nw = pick(req, m_ptr, m_win, hold, m_level);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr <= 0; m_level <= 0; m_win <= -1; m_data <= '0; m_push <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_win  <= m_nw;
            m_push <= (m_nw >= 0);
            if (m_nw >= 0) begin
                m_data <= req_data[m_nw*DW +: DW];
                m_ptr  <= (m_nw + 1) % NR;
            end
            m_level <= m_level + ((m_nw >= 0) ? 1 : 0) - ((fifo_pop && f_cnt > 0 && m_level > 0) ? 1 : 0);
            m_ovf   <= m_ovf || (m_push && f_cnt == DEPTH);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("grant", int'(grant), (m_win >= 0) ? (1 << m_win) : 0);
            check("fifo_push", int'(fifo_push), int'(m_push));
            check("fifo_val_in", int'(fifo_val_in), int'(m_data));
            check("level", int'(level), m_level);
            check("overflow_err", int'(overflow_err), int'(m_ovf));
        end
    end

    // Producer agents: hold a sample until granted, then present the next one.
    logic [NR-1:0] active;
    logic          hold_c, pop_c;
    int            seq [NR];

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (grant[i]) seq[i]++;
            req[i] = active[i];
            req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
        hold     = hold_c;
        fifo_pop = pop_c;
    endtask

    function automatic int gidx(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return -1;
    endfunction

    int log_q[$];
    int gcount, prev_g, last_g;
    int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst = 1'b0; req = '0; req_data = '0; hold = 1'b0; fifo_pop = 1'b0;
        active = '0; hold_c = 1'b0; pop_c = 1'b0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        tick(); tick();
        rst = 1'b1;

        // idle after reset
        for (int t = 0; t < 5; t++) begin
            tick();
            check("idle_grant", int'(grant), 0);
            check("idle_push", int'(fifo_push), 0);
            check("idle_level", int'(level), 0);
            check("idle_ovf", int'(overflow_err), 0);
        end

        // full contention with a consumer popping every cycle
        active = 4'b1111; pop_c = 1'b1;
        log_q.delete();
        for (int t = 0; t < 12; t++) begin
            tick();
            if (gidx(grant) >= 0) log_q.push_back(gidx(grant));
        end
        check("rr_count", log_q.size(), 11);
        for (int i = 0; i < 8; i++) check("rr_order", log_q[i], exp_rr[i]);
        check("rr_steady_level", int'(level), 2);
        active = '0;
        for (int t = 0; t < 6; t++) tick();
        check("drain1_level", int'(level), 0);

        // single requester: grants only on alternate cycles
        active = 4'b0100;
        gcount = 0; prev_g = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (grant != '0) begin
                check("single_who", int'(grant), 4);
                check("single_no_back2back", prev_g, 0);
                gcount++;
            end
            prev_g = (grant != '0) ? 1 : 0;
        end
        check("single_count", gcount, 4);
        active = '0;
        for (int t = 0; t < 6; t++) tick();
        check("drain2_level", int'(level), 0);

        // fill to the full boundary with no pops
        pop_c = 1'b0; active = 4'b0010;
        gcount = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (grant != '0) gcount++;
        end
        check("fill_pushes", gcount, 16);
        check("fill_level", int'(level), 16);
        check("fill_model_level", m_level, 16);
        check("fill_no_grant", int'(grant), 0);
        check("fill_ovf", int'(overflow_err), 0);
        pop_c = 1'b1; tick();
        pop_c = 1'b0; tick();
        check("pop1_level", int'(level), 15);
        check("pop1_grant", int'(grant), 0);
        tick();
        check("refill_grant", int'(grant), 2);
        check("refill_level", int'(level), 16);

        // pops overlapping a push while the FIFO is full
        pop_c = 1'b1; tick();
        tick();
        check("pp_level_a", int'(level), 15);
        pop_c = 1'b0; tick();
        check("pp_level_b", int'(level), 15);
        check("pp_grant_b", int'(grant), 2);
        tick(); tick();
        check("pp_level_c", int'(level), 16);
        check("pp_grant_c", int'(grant), 2);
        check("pp_ovf", int'(overflow_err), 0);
        active = '0; pop_c = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        check("drain3_level", int'(level), 0);

        // hold during contention
        active = 4'b1111;
        tick(); tick(); tick();
        hold_c = 1'b1; tick();
        last_g = gidx(grant);
        check("hold_pending_seen", (last_g >= 0) ? 1 : 0, 1);
        for (int t = 0; t < 3; t++) begin
            tick();
            check("hold_no_grant", int'(grant), 0);
        end
        hold_c = 1'b0; tick();
        check("hold_release_lag", int'(grant), 0);
        tick();
        check("hold_resume", gidx(grant), (last_g + 1) % NR);

        // asynchronous reset mid-stream
        tick(); tick();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_grant", int'(grant), 0);
        check("arst_push", int'(fifo_push), 0);
        check("arst_val", int'(fifo_val_in), 0);
        check("arst_level", int'(level), 0);
        check("arst_ovf", int'(overflow_err), 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_grant", int'(grant), 1);
        tick();
        check("post_rst_next", int'(grant), 2);

        active = '0;
        for (int t = 0; t < 4; t++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
